sum_target_scorer: RTL and testbench

SUM_TARGET_SCORER -- requirements
Module: sum_target_scorer

---
 rtl/sum_target_scorer.sv | 98 +++++++++
 tb/tb_sum_target_scorer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sum_target_scorer.sv
// Sum-target game scorer: counts qualified hits of sum_in == TARGET and flags a win.
// Optional macro SCORE_SAT_EN saturates the score at its maximum instead of wrapping.
module sum_target_scorer #(
   parameter int unsigned SUM_W     = 4,
   parameter int unsigned TARGET    = 15,
   parameter int unsigned SCORE_W   = 4,
   parameter int unsigned HOLD_CYC  = 4,
   parameter int unsigned WIN_SCORE = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [SUM_W-1:0]   sum_in,
   input  logic               clear,
   output logic               light_g,
   output logic               light_r,
   output logic [SCORE_W-1:0] score,
   output logic               score_pulse,
   output logic               win
);

   localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   typedef enum logic [1:0] {IDLE, QUAL, SCORED, WON} state_t;

   state_t              state;
   logic [HOLD_W-1:0]   hold;
   logic                match_c;
   logic [HOLD_W-1:0]   hold_inc_c;
   logic [SCORE_W-1:0]  score_inc_c;
   logic                win_hit_c;
   logic                hit_c;
   logic                lg_c;

   assign match_c    = (sum_in == SUM_W'(TARGET));
   assign hold_inc_c = HOLD_W'(hold + HOLD_W'(1));

`ifdef SCORE_SAT_EN
   assign score_inc_c = (score == SCORE_MAX) ? score : SCORE_W'(score + SCORE_W'(1));
`else
   assign score_inc_c = SCORE_W'(score + SCORE_W'(1));
`endif

   // Compare at full width so an unreachable WIN_SCORE never aliases after truncation
   assign win_hit_c = (WIN_SCORE != 0) && (32'(score_inc_c) == WIN_SCORE);

   assign hit_c = match_c &&
                  (((state == IDLE) && (HOLD_CYC == 1)) ||
                   ((state == QUAL) && (hold_inc_c == HOLD_W'(HOLD_CYC))));

   assign lg_c = (state == WON) || match_c;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state       <= IDLE;
         hold        <= '0;
         score       <= '0;
         win         <= 1'b0;
         score_pulse <= 1'b0;
         light_g     <= 1'b0;
         light_r     <= 1'b1;
      end else begin
         light_g     <= lg_c;
         light_r     <= ~lg_c;
         score_pulse <= 1'b0;
         if (hit_c) begin
            score       <= score_inc_c;
            score_pulse <= (score_inc_c != score);
            hold        <= '0;
            win         <= win_hit_c;
            state       <= win_hit_c ? WON : SCORED;
         end else begin
            case (state)
               IDLE: begin
                  if (match_c) begin
                     state <= QUAL;
                     hold  <= HOLD_W'(1);
                  end
               end
               QUAL: begin
                  if (match_c) begin
                     hold <= hold_inc_c;
                  end else begin
                     state <= IDLE;
                     hold  <= '0;
                  end
               end
               // Re-arming needs at least one non-matching sample
               SCORED: begin
                  if (!match_c) state <= IDLE;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sum_target_scorer.sv
// Randomised and directed bench for sum_target_scorer: two configurations against a run-length model.
module tb_sum_target_scorer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clear = 1'b0;
   logic [3:0] sum_in = 4'd0;

   logic       a_lg, a_lr, a_pulse, a_win;
   logic [3:0] a_score;
   logic       b_lg, b_lr, b_pulse, b_win;
   logic [3:0] b_score;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sum_target_scorer #(.SUM_W(4), .TARGET(15), .SCORE_W(4), .HOLD_CYC(4), .WIN_SCORE(10)) dut_a (
      .clk(clk), .rst(rst), .sum_in(sum_in), .clear(clear),
      .light_g(a_lg), .light_r(a_lr), .score(a_score), .score_pulse(a_pulse), .win(a_win));

   sum_target_scorer #(.SUM_W(4), .TARGET(15), .SCORE_W(4), .HOLD_CYC(1), .WIN_SCORE(0)) dut_b (
      .clk(clk), .rst(rst), .sum_in(sum_in), .clear(clear),
      .light_g(b_lg), .light_r(b_lr), .score(b_score), .score_pulse(b_pulse), .win(b_win));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Model: a hit is the moment a run of consecutive matches reaches HOLD samples
   localparam int HOLD [2] = '{4, 1};
   localparam int WINS [2] = '{10, 0};
   localparam int MAXS     = 15;

   int m_run [2];
   int m_score [2];
   bit m_won [2];
   bit m_lg [2];
   bit m_pulse [2];
   bit m_valid = 1'b0;

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         m_pulse[i] = 1'b0;
         if (rst || clear) begin
            m_run[i] = 0; m_score[i] = 0; m_won[i] = 1'b0; m_lg[i] = 1'b0;
         end else if (m_won[i]) begin
            m_lg[i] = 1'b1;
         end else begin
            m_lg[i] = (sum_in == 4'd15);
            if (sum_in == 4'd15) begin
               if (m_run[i] <= HOLD[i]) m_run[i]++;
               if (m_run[i] == HOLD[i]) begin
                  int nxt;
                  nxt = m_score[i] + 1;
`ifdef SCORE_SAT_EN
                  if (nxt > MAXS) nxt = MAXS;
`else
                  if (nxt > MAXS) nxt = 0;
`endif
                  m_pulse[i] = (nxt != m_score[i]);
                  m_score[i] = nxt;
                  if (WINS[i] != 0 && m_score[i] == WINS[i]) m_won[i] = 1'b1;
               end
            end else begin
               m_run[i] = 0;
            end
         end
      end
      if (rst) m_valid = 1'b1;
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("a_light_g", 32'(a_lg), 32'(m_lg[0]));
         check("a_light_r", 32'(a_lr), 32'(!m_lg[0]));
         check("a_score", 32'(a_score), 32'(m_score[0]));
         check("a_pulse", 32'(a_pulse), 32'(m_pulse[0]));
         check("a_win", 32'(a_win), 32'(m_won[0]));
         check("b_light_g", 32'(b_lg), 32'(m_lg[1]));
         check("b_light_r", 32'(b_lr), 32'(!m_lg[1]));
         check("b_score", 32'(b_score), 32'(m_score[1]));
         check("b_pulse", 32'(b_pulse), 32'(m_pulse[1]));
         check("b_win", 32'(b_win), 32'(m_won[1]));
      end
   end

   task automatic cyc(input logic [3:0] val, input int n);
      for (int k = 0; k < n; k++) begin
         sum_in = val;
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(4'd0, 2);
      rst = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      do_reset();
      check("reset_score", 32'(a_score), 32'd0);
      check("reset_light_r", 32'(a_lr), 32'd1);
      check("reset_win", 32'(a_win), 32'd0);

      // Sixteen single-sample hits on the HOLD=1, no-win instance
      for (int k = 0; k < 15; k++) begin
         cyc(4'd15, 1);
         cyc(4'd0, 1);
      end
      check("b_score_15", 32'(b_score), 32'd15);
      cyc(4'd15, 1);
`ifdef SCORE_SAT_EN
      check("b_sat_score", 32'(b_score), 32'd15);
      check("b_sat_pulse", 32'(b_pulse), 32'd0);
`else
      check("b_wrap_score", 32'(b_score), 32'd0);
      check("b_wrap_pulse", 32'(b_pulse), 32'd1);
`endif
      cyc(4'd0, 1);

      // Basic qualified hit
      do_reset();
      cyc(4'd15, 1);
      check("hit_light_g_edge1", 32'(a_lg), 32'd1);
      check("hit_score_edge1", 32'(a_score), 32'd0);
      cyc(4'd15, 2);
      check("hit_score_edge3", 32'(a_score), 32'd0);
      cyc(4'd15, 1);
      check("hit_score_edge4", 32'(a_score), 32'd1);
      check("hit_pulse_edge4", 32'(a_pulse), 32'd1);
      cyc(4'd0, 1);
      check("hit_pulse_edge5", 32'(a_pulse), 32'd0);
      check("hit_light_g_edge5", 32'(a_lg), 32'd0);

      // Broken streak never qualifies
      do_reset();
      cyc(4'd15, 3);
      cyc(4'd7, 1);
      check("broken_light_g", 32'(a_lg), 32'd0);
      cyc(4'd15, 3);
      check("broken_score", 32'(a_score), 32'd0);
      cyc(4'd0, 1);

      // Long hold counts once, re-arm after one miss
      do_reset();
      cyc(4'd15, 20);
      check("long_hold_score", 32'(a_score), 32'd1);
      cyc(4'd0, 1);
      cyc(4'd15, 4);
      check("rearm_score", 32'(a_score), 32'd2);
      cyc(4'd0, 1);

      // Ten hits win; further hits ignored; clear with match restarts
      do_reset();
      for (int k = 0; k < 9; k++) begin
         cyc(4'd15, 4);
         cyc(4'd0, 1);
      end
      cyc(4'd15, 4);
      check("win_level", 32'(a_win), 32'd1);
      check("win_score", 32'(a_score), 32'd10);
      cyc(4'd0, 3);
      check("won_light_g", 32'(a_lg), 32'd1);
      for (int k = 0; k < 3; k++) begin
         cyc(4'd15, 4);
         cyc(4'd0, 1);
      end
      check("won_score_frozen", 32'(a_score), 32'd10);
      clear = 1'b1;
      cyc(4'd15, 1);
      clear = 1'b0;
      check("clear_score", 32'(a_score), 32'd0);
      check("clear_win", 32'(a_win), 32'd0);
      check("clear_light_r", 32'(a_lr), 32'd1);
      check("clear_light_g", 32'(a_lg), 32'd0);

      // Reset mid-qualification and reset together with clear
      do_reset();
      cyc(4'd15, 3);
      rst = 1'b1;
      cyc(4'd15, 1);
      check("rst_qual_score", 32'(a_score), 32'd0);
      check("rst_qual_light_g", 32'(a_lg), 32'd0);
      check("rst_qual_light_r", 32'(a_lr), 32'd1);
      clear = 1'b1;
      cyc(4'd15, 1);
      rst = 1'b0;
      clear = 1'b0;
      check("rst_clear_pulse", 32'(a_pulse), 32'd0);
      cyc(4'd15, 3);
      check("after_rst_3", 32'(a_score), 32'd0);
      cyc(4'd15, 1);
      check("after_rst_4", 32'(a_score), 32'd1);

      // Randomised play, mostly on-target with occasional clear and reset
      for (int k = 0; k < 3000; k++) begin
         sum_in = ($urandom_range(0, 9) < 8) ? 4'd15 : 4'($urandom_range(0, 15));
         clear  = ($urandom_range(0, 199) == 0);
         rst    = ($urandom_range(0, 399) == 0);
         @(negedge clk);
      end
      rst = 1'b0;
      clear = 1'b0;
      cyc(4'd0, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
